// File: rtl/pipe_adder.sv
// Pipelined add/subtract with wrap or saturate on a valid/ready stream.
// The carry chain is cut into STAGES chunks, one register stage per chunk.

module pipe_adder_chunk #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

module pipe_adder #(
  parameter int bitwidth = 15,
  parameter int STAGES   = 3,
  parameter bit SIGNED   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bitwidth-1:0] inp1,
  input  logic [bitwidth-1:0] inp2,
  input  logic                sub,
  input  logic                sat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [bitwidth-1:0] out,
  output logic                carry,
  output logic                ovf
);
  localparam int CW  = (bitwidth + STAGES - 1) / STAGES;
  localparam int MSB = bitwidth - 1;

  // b is already inverted for subtraction; s fills in one chunk per stage
  typedef struct packed {
    logic [bitwidth-1:0] a;
    logic [bitwidth-1:0] b;
    logic [bitwidth-1:0] s;
    logic                c;
    logic                sub;
    logic                sat;
  } stg_t;

  logic              adv;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign vld_pipe  = {vld_q, in_valid & adv};
  assign out_valid = vld_q[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[STAGES-1:0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k * CW < bitwidth) ? k * CW : bitwidth;
    localparam int HI = ((k + 1) * CW < bitwidth) ? (k + 1) * CW : bitwidth;
    localparam int W  = HI - LO;

    stg_t cur, nx;

    if (k == 0) begin : g_entry
      assign cur = '{a: inp1, b: (sub ? ~inp2 : inp2), s: '0,
                     c: sub, sub: sub, sat: sat};
    end else begin : g_reg
      stg_t r;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      r <= '0;
        else if (adv) r <= g_stage[k-1].nx;
      end
      assign cur = r;
    end

    // Ceil-sized chunks can leave a trailing stage with no bits; it just forwards.
    if (W > 0) begin : g_add
      logic [W-1:0] sum;
      logic         cout;
      pipe_adder_chunk #(.W(W)) u_chunk (
        .a   (cur.a[LO +: W]),
        .b   (cur.b[LO +: W]),
        .cin (cur.c),
        .sum (sum),
        .cout(cout)
      );
      always_comb begin
        nx              = cur;
        nx.s[LO +: W]   = sum;
        nx.c            = cout;
      end
    end else begin : g_pass
      assign nx = cur;
    end
  end

  stg_t                fin;
  logic                ov_c;
  logic [bitwidth-1:0] res_c;

  assign fin = g_stage[STAGES-1].nx;

  always_comb begin
    if (SIGNED) ov_c = (fin.a[MSB] == fin.b[MSB]) && (fin.s[MSB] != fin.a[MSB]);
    else        ov_c = fin.sub ? ~fin.c : fin.c;
    res_c = fin.s;
    if (fin.sat && ov_c) begin
      if (!SIGNED)          res_c = fin.sub ? '0 : '1;
      else if (fin.a[MSB])  res_c = {1'b1, {MSB{1'b0}}};
      else                  res_c = {1'b0, {MSB{1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (adv) begin
      out   <= res_c;
      carry <= fin.c;
      ovf   <= ov_c;
    end
  end
endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: six parameter configurations driven in parallel,
// each with its own scoreboard, plus directed latency/value checks.

module tb_pipe_adder;
  localparam int NCFG = 6;
  localparam int BW [NCFG] = '{15, 15, 15, 15, 32, 8};
  localparam int ST [NCFG] = '{3,  3,  1,  15, 4,  3};
  localparam bit SG [NCFG] = '{0,  1,  0,  1,  0,  1};

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, sub, sat;
  logic [31:0] a, b;

  logic [NCFG-1:0] rdy_v, vld_v, car_v, ovf_v;
  logic [31:0]     out_v [NCFG];

  int checks = 0;
  int errors = 0;
  bit final_chk = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: full-width arithmetic, no chunking.  Returns {ovf, carry, out}.
  function automatic logic [33:0] model(input int w, input bit sg, input logic [31:0] x,
                                        input logic [31:0] y, input logic sb, input logic st);
    logic [63:0] m, xx, yy, f;
    logic [31:0] r;
    logic        cy, ov, xm, ym, rm;
    m  = (64'd1 << w) - 64'd1;
    xx = {32'd0, x} & m;
    yy = sb ? (~{32'd0, y} & m) : ({32'd0, y} & m);
    f  = xx + yy + {63'd0, sb};
    r  = 32'(f & m);
    cy = f[w];
    xm = xx[w-1];
    ym = yy[w-1];
    rm = r[w-1];
    if (sg) ov = (xm == ym) && (rm != xm);
    else    ov = sb ? ~cy : cy;
    if (st && ov) begin
      if (!sg)    r = sb ? 32'd0 : 32'(m);
      else if (xm) r = 32'(64'd1 << (w - 1));
      else         r = 32'(m >> 1);
    end
    return {ov, cy, r};
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W = BW[g];
    logic          in_rdy, o_vld, c, ov;
    logic [W-1:0]  o;
    logic [33:0]   q[$];
    logic [33:0]   e;
    bit            fc_done = 1'b0;

    pipe_adder #(.bitwidth(W), .STAGES(ST[g]), .SIGNED(SG[g])) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_rdy),
      .inp1     (a[W-1:0]),
      .inp2     (b[W-1:0]),
      .sub      (sub),
      .sat      (sat),
      .out_valid(o_vld),
      .out_ready(out_ready),
      .out      (o),
      .carry    (c),
      .ovf      (ov)
    );

    assign rdy_v[g] = in_rdy;
    assign vld_v[g] = o_vld;
    assign car_v[g] = c;
    assign ovf_v[g] = ov;
    assign out_v[g] = 32'(o);

    // Inputs change just after posedge, so at negedge they show the coming handshake.
    always @(negedge clk) begin
      if (rst) q.delete();
      else begin
        if (o_vld && out_ready) begin
          if (q.size() == 0) chk($sformatf("cfg%0d_stale", g), {63'd0, o_vld}, 64'd0);
          else begin
            e = q.pop_front();
            chk($sformatf("cfg%0d_res", g), {30'd0, ov, c, 32'(o)}, {30'd0, e});
          end
        end
        if (in_valid && in_rdy) q.push_back(model(W, SG[g], a, b, sub, sat));
      end
      if (final_chk && !fc_done) begin
        chk($sformatf("cfg%0d_drain", g), 64'(q.size()), 64'd0);
        fc_done = 1'b1;
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic sb, input logic st, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = x;
    b         = y;
    sub       = sb;
    sat       = st;
    out_ready = ordy;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [31:0] x, y;
    logic        sb, st;
    int          c;
    logic [31:0] o;
    logic        cy, ov;
  } dvec_t;

  dvec_t       dv [8];
  logic [24:0] v, ev;
  logic [31:0] snap_o;
  logic        snap_c, snap_v;

  initial begin
    dv[0] = '{x: 32'h7FFF, y: 32'h1, sb: 0, st: 0, c: 0, o: 32'h0000, cy: 1, ov: 1};
    dv[1] = '{x: 32'h7FFF, y: 32'h1, sb: 0, st: 1, c: 0, o: 32'h7FFF, cy: 1, ov: 1};
    dv[2] = '{x: 32'h0003, y: 32'h5, sb: 1, st: 0, c: 0, o: 32'h7FFE, cy: 0, ov: 1};
    dv[3] = '{x: 32'h0003, y: 32'h5, sb: 1, st: 1, c: 0, o: 32'h0000, cy: 0, ov: 1};
    dv[4] = '{x: 32'h0005, y: 32'h3, sb: 1, st: 0, c: 0, o: 32'h0002, cy: 1, ov: 0};
    dv[5] = '{x: 32'h3FFF, y: 32'h1, sb: 0, st: 1, c: 1, o: 32'h3FFF, cy: 0, ov: 1};
    dv[6] = '{x: 32'h4000, y: 32'h1, sb: 1, st: 1, c: 1, o: 32'h4000, cy: 1, ov: 1};
    dv[7] = '{x: 32'h7FFF, y: 32'h1, sb: 0, st: 0, c: 1, o: 32'h0000, cy: 1, ov: 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("rst_vld%0d", g), {63'd0, vld_v[g]}, 64'd0);
      chk($sformatf("rst_rdy%0d", g), {63'd0, rdy_v[g]}, 64'd1);
      chk($sformatf("rst_out%0d", g), {29'd0, ovf_v[g], car_v[g], out_v[g]}, 64'd0);
    end
    @(posedge clk); #1; rst = 1'b0;

    // Directed values with exact latency on the STAGES=3 configurations
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, dv[i].x, dv[i].y, dv[i].sb, dv[i].st, 1'b1);
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); @(negedge clk);
      chk($sformatf("dir%0d_early", i), {63'd0, vld_v[dv[i].c]}, 64'd0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("dir%0d_vld", i), {63'd0, vld_v[dv[i].c]}, 64'd1);
      chk($sformatf("dir%0d_out", i), {32'd0, out_v[dv[i].c]}, {32'd0, dv[i].o});
      chk($sformatf("dir%0d_carry", i), {63'd0, car_v[dv[i].c]}, {63'd0, dv[i].cy});
      chk($sformatf("dir%0d_ovf", i), {63'd0, ovf_v[dv[i].c]}, {63'd0, dv[i].ov});
      repeat (3) @(posedge clk);
    end
    repeat (20) @(posedge clk);

    // Streaming: 20 back-to-back, expect valid in cycles 3..22 on cfg0
    for (int i = 0; i < 25; i++) begin
      drive(i < 20, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b1);
      @(negedge clk);
      v[i]  = vld_v[0];
      ev[i] = (i >= 3) && (i <= 22);
    end
    chk("stream_vld", {39'd0, v}, {39'd0, ev});
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);

    // Backpressure: fill, then hold out_ready low for 5 cycles
    for (int i = 0; i < 4; i++) drive(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b0);
      @(negedge clk);
      if (i == 0) begin
        snap_o = out_v[0]; snap_c = car_v[0]; snap_v = ovf_v[0];
      end
      chk("bp_vld", {63'd0, vld_v[0]}, 64'd1);
      chk("bp_rdy", {63'd0, rdy_v[0]}, 64'd0);
      chk("bp_hold", {30'd0, ovf_v[0], car_v[0], out_v[0]}, {30'd0, snap_v, snap_c, snap_o});
    end

    for (int i = 0; i < 200; i++)
      drive(1'($urandom), rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    repeat (40) @(posedge clk);

    // Reset with transactions in flight
    for (int i = 0; i < 3; i++) drive(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b1);
    @(posedge clk);
    #1; in_valid = 1'b0; rst = 1'b1;
    #1;
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("mid_rst_vld%0d", g), {63'd0, vld_v[g]}, 64'd0);
      chk($sformatf("mid_rst_out%0d", g), {29'd0, ovf_v[g], car_v[g], out_v[g]}, 64'd0);
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (30) @(posedge clk);

    final_chk = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
